// File: rtl/ibex_pkg.sv
// Shared types for the Ibex EX sequencing controller.
// Op classes, controller states and the op-legality helper.
package ibex_pkg;

  typedef enum logic [1:0] {
    EX_OP_ALU    = 2'd0,
    EX_OP_ALU_MC = 2'd1,
    EX_OP_MULT   = 2'd2,
    EX_OP_DIV    = 2'd3
  } ex_op_class_e;

  typedef enum logic {
    EX_IDLE = 1'b0,
    EX_EXEC = 1'b1
  } ex_ctrl_state_e;

  localparam int unsigned IMD_W = 34;
  localparam int unsigned CYC_W = 8;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  function automatic logic op_legal(
    input ex_op_class_e c,
    input int unsigned  rv32m,
    input int unsigned  rv32b
  );
    logic ok;
    ok = 1'b1;
    if (c == EX_OP_MULT || c == EX_OP_DIV) begin
      ok = (rv32m != 0);
    end else if (c == EX_OP_ALU_MC) begin
      ok = (rv32b != 0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/ibex_ex_imd_regs.sv
// Two 34-bit intermediate-value registers shared by ALU and mult/div.
// Per-register write enable; synchronous clear has priority.
module ibex_ex_imd_regs
  import ibex_pkg::*;
(
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic [1:0]         we_i,
  input  logic [2*IMD_W-1:0] d_i,
  output logic [2*IMD_W-1:0] q_o
);

  logic [IMD_W-1:0] r_q0;
  logic [IMD_W-1:0] r_q1;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_q0 <= '0;
    end else if (we_i[0]) begin
      r_q0 <= d_i[IMD_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_q1 <= '0;
    end else if (we_i[1]) begin
      r_q1 <= d_i[2*IMD_W-1:IMD_W];
    end
  end

  assign q_o = {r_q1, r_q0};

endmodule

// File: rtl/ibex_ex_ctrl.sv
// EX sequencing controller: op acceptance, mult/div strobes,
// cycle counting and a one-entry writeback buffer.
module ibex_ex_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned RV32M = 2,
  parameter int unsigned RV32B = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [1:0]       op_class_i,
  input  logic             flush_i,
  input  logic             ex_valid_i,
  input  logic [31:0]      result_ex_i,
  input  logic [1:0]       imd_val_we_i,
  input  logic [67:0]      imd_val_d_i,
  output logic [67:0]      imd_val_q_o,
  output logic             alu_instr_first_cycle_o,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             mult_sel_o,
  output logic             div_sel_o,
  output logic             multdiv_ready_id_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic             wb_err_o,
  output logic [CYC_W-1:0] wb_cycles_o,
  output logic             busy_o
);

  ex_ctrl_state_e   r_state;
  ex_op_class_e     r_class;
  logic             r_first;
  logic [CYC_W-1:0] r_cnt;
  logic             r_wb_valid;
  logic [31:0]      r_wb_result;
  logic             r_wb_err;
  logic [CYC_W-1:0] r_wb_cycles;

  logic w_exec;
  logic w_idle;
  logic w_clr;
  logic w_slot_free;
  logic w_done;
  logic w_legal;
  logic w_ready;
  logic w_acc;
  logic w_acc_legal;
  logic w_acc_ill;
  logic w_is_mult;
  logic w_is_div;

  assign w_exec      = (r_state == EX_EXEC);
  assign w_idle      = (r_state == EX_IDLE);
  assign w_clr       = !rst_ni | flush_i;
  assign w_slot_free = !r_wb_valid | wb_ready_i;
  assign w_done      = w_exec & ex_valid_i & w_slot_free;
  assign w_legal     = op_legal(ex_op_class_e'(op_class_i), RV32M, RV32B);

  // An illegal op writes the buffer directly, so it cannot share a
  // cycle with a completing op that is filling the same slot.
  assign w_ready = !flush_i & (w_legal ? (w_idle | w_done)
                                       : (w_idle & w_slot_free));

  assign w_acc       = instr_valid_i & w_ready;
  assign w_acc_legal = w_acc & w_legal;
  assign w_acc_ill   = w_acc & !w_legal;

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_state <= EX_IDLE;
      r_class <= EX_OP_ALU;
      r_first <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_first <= w_acc_legal;
      if (w_acc_legal) begin
        r_state <= EX_EXEC;
        r_class <= ex_op_class_e'(op_class_i);
        r_cnt   <= CYC_W'(1);
      end else begin
        if (w_done) begin
          r_state <= EX_IDLE;
        end
        if (w_exec && r_cnt != CYC_MAX) begin
          r_cnt <= r_cnt + CYC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_wb_valid  <= 1'b0;
      r_wb_result <= '0;
      r_wb_err    <= 1'b0;
      r_wb_cycles <= '0;
    end else if (w_done) begin
      r_wb_valid  <= 1'b1;
      r_wb_result <= result_ex_i;
      r_wb_err    <= 1'b0;
      r_wb_cycles <= r_cnt;
    end else if (w_acc_ill) begin
      r_wb_valid  <= 1'b1;
      r_wb_result <= '0;
      r_wb_err    <= 1'b1;
      r_wb_cycles <= '0;
    end else if (wb_ready_i) begin
      r_wb_valid  <= 1'b0;
    end
  end

  ibex_ex_imd_regs u_imd_regs (
    .clk_i (clk_i),
    .clr_i (w_clr),
    .we_i  (imd_val_we_i & {2{w_exec}}),
    .d_i   (imd_val_d_i),
    .q_o   (imd_val_q_o)
  );

  assign w_is_mult = (r_class == EX_OP_MULT);
  assign w_is_div  = (r_class == EX_OP_DIV);

  assign instr_ready_o           = w_ready;
  assign mult_sel_o              = w_exec & w_is_mult;
  assign div_sel_o               = w_exec & w_is_div;
  assign mult_en_o               = w_exec & w_is_mult;
  assign div_en_o                = w_exec & w_is_div;
  assign alu_instr_first_cycle_o = w_exec & r_first;
  assign multdiv_ready_id_o      = w_exec & w_slot_free;
  assign wb_valid_o              = r_wb_valid;
  assign wb_result_o             = r_wb_result;
  assign wb_err_o                = r_wb_err;
  assign wb_cycles_o             = r_wb_cycles;
  assign busy_o                  = w_exec | r_wb_valid;

endmodule
